// File: rtl/mul26_share_ctrl_pkg.sv
// Shared constants for the 26x26 multiplier sharing controller.
// Owner encodings identify which requester an in-flight op belongs to.
package mul26_share_ctrl_pkg;

  localparam int unsigned MUL_W      = 26;
  localparam int unsigned MUL_PW     = 2 * MUL_W;
  localparam int unsigned TW_DEFAULT = 4;

  localparam logic OWN_FMUL = 1'b0;
  localparam logic OWN_FDIV = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant moves only when a grant is actually taken.
// Reset is synchronous and active-low.
module rr_arb2
  import mul26_share_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       clrn_i,
  input  logic [1:0] req_i,
  input  logic       acc_i,
  input  logic       acc_idx_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // A port is only blocked when the other port is contending and wins.
  always_comb begin
    gnt_o = 2'b11;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == OWN_FDIV) ? 2'b01 : 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (acc_i) begin
      last_d = acc_idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clrn_i) begin
      last_q <= OWN_FDIV;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wallace_26x26_product.sv
// Unsigned 26x26 full-width product, purely combinational.
// The reduction tree is left to synthesis to build from the multiply operator.
module wallace_26x26_product
  import mul26_share_ctrl_pkg::*;
(
  input  logic [MUL_W-1:0]  a_i,
  input  logic [MUL_W-1:0]  b_i,
  output logic [MUL_PW-1:0] prod_o
);

  assign prod_o = MUL_PW'(a_i) * MUL_PW'(b_i);

endmodule

// File: rtl/mul26_share_ctrl.sv
// Shares one 26x26 multiplier between the FP multiply pipe (port 0) and the
// divide/sqrt iteration unit (port 1) through a two-stage registered pipeline.
module mul26_share_ctrl
  import mul26_share_ctrl_pkg::*;
#(
  parameter int unsigned W  = MUL_W,
  parameter int unsigned TW = TW_DEFAULT
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [W-1:0]    req_a0,
  input  logic [W-1:0]    req_b0,
  input  logic [W-1:0]    req_a1,
  input  logic [W-1:0]    req_b1,
  input  logic [TW-1:0]   req_tag0,
  input  logic [TW-1:0]   req_tag1,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [2*W-1:0]  rsp_prod,
  output logic [TW-1:0]   rsp_tag,
  input  logic [1:0]      flush,
  output logic            idle
);

  logic            s1_v_q, s1_v_d;
  logic            s1_own_q;
  logic [W-1:0]    s1_a_q, s1_b_q;
  logic [TW-1:0]   s1_tag_q;

  logic            s2_v_q, s2_v_d;
  logic            s2_own_q;
  logic [2*W-1:0]  s2_prod_q;
  logic [TW-1:0]   s2_tag_q;

  logic            s1_flush, s2_flush, s2_hs;
  logic            adv1, adv2;
  logic [1:0]      elig, gnt, acc;
  logic            acc_any, acc_idx;
  logic [2*W-1:0]  mul_prod;

  // Response side: a flushed owner never sees its result, even with rsp_ready high.
  always_comb begin
    rsp_valid           = '0;
    rsp_valid[OWN_FMUL] = s2_v_q && (s2_own_q == OWN_FMUL) && !flush[OWN_FMUL];
    rsp_valid[OWN_FDIV] = s2_v_q && (s2_own_q == OWN_FDIV) && !flush[OWN_FDIV];
  end

  assign s2_hs    = |(rsp_valid & rsp_ready);
  assign s2_flush = s2_v_q && flush[s2_own_q];
  assign s1_flush = s1_v_q && flush[s1_own_q];
  assign adv2     = !s2_v_q || s2_hs || s2_flush;
  assign adv1     = !s1_v_q || adv2;

  // A port being flushed does not contend, so the other port can take the slot.
  assign elig = req_valid & ~flush;

  rr_arb2 u_arb (
    .clk_i     (clk),
    .clrn_i    (clrn),
    .req_i     (elig),
    .acc_i     (acc_any),
    .acc_idx_i (acc_idx),
    .gnt_o     (gnt)
  );

  assign req_ready = {2{adv1}} & ~flush & gnt;
  assign acc       = req_valid & req_ready;
  assign acc_any   = |acc;
  assign acc_idx   = acc[OWN_FDIV];

  wallace_26x26_product u_mul (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .prod_o (mul_prod)
  );

  always_comb begin
    s1_v_d = s1_v_q;
    if (adv1) begin
      s1_v_d = acc_any;
    end else if (s1_flush) begin
      s1_v_d = 1'b0;
    end
    s2_v_d = s2_v_q;
    if (adv2) begin
      s2_v_d = s1_v_q && !s1_flush;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // Payload registers only move when their stage advances with real data.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_own_q  <= OWN_FMUL;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_tag_q  <= '0;
      s2_own_q  <= OWN_FMUL;
      s2_prod_q <= '0;
      s2_tag_q  <= '0;
    end else begin
      if (adv1 && acc_any) begin
        s1_own_q <= acc_idx;
        s1_a_q   <= acc_idx ? req_a1 : req_a0;
        s1_b_q   <= acc_idx ? req_b1 : req_b0;
        s1_tag_q <= acc_idx ? req_tag1 : req_tag0;
      end
      if (adv2 && s1_v_q) begin
        s2_own_q  <= s1_own_q;
        s2_prod_q <= mul_prod;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign rsp_prod = s2_v_q ? s2_prod_q : '0;
  assign rsp_tag  = s2_v_q ? s2_tag_q : '0;
  assign idle     = !s1_v_q && !s2_v_q;

endmodule

// File: doc/mul26_share_ctrl.md
Name: mul26_share_ctrl

Overview:
- Shares one 26x26 Wallace-tree multiplier (existing wallace_26x26_product) between two requesters: port 0 = FP multiply pipeline, port 1 = FP divide/sqrt Newton-Raphson iteration unit.
- Round-robin arbitration, 2-stage registered pipeline around the multiplier, per-requester response handshake with backpressure.
- Per-requester flush drops in-flight work on trap/interrupt cancel.

Parameters:
- W, 26, operand width; product width is 2*W. Fixed at 26 to match the multiplier.
- TW, 4, requester tag width; the tag is returned unchanged with the product.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  synchronous active-low reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted when valid&ready.
- req_a0, req_b0  in  26 each  operands, requester 0.
- req_a1, req_b1  in  26 each  operands, requester 1.
- req_tag0, req_tag1  in  TW each  request tags.
- rsp_valid  out  2  product valid for requester i.
- rsp_ready  in  2  requester i accepts the product.
- rsp_prod  out  52  product, shared bus; meaningful only for the requester whose rsp_valid bit is set.
- rsp_tag  out  TW  tag of the returned product.
- flush  in  2  flush[i] kills all of requester i's in-flight ops.
- idle  out  1  high when both pipeline stages are empty.

Behaviour:
Pipeline registers:
- S1 holds valid, owner, a, b and tag. S1.a and S1.b feed the multiplier.
- S2 holds valid, owner, prod[51:0] and tag. S2 drives the response outputs.

Timing and arbitration:
- Accept at edge N gives rsp_valid high after edge N+2, i.e. 2-cycle latency when there is no stall.
- req_ready[i] = adv1 & ~flush[i] & grant[i], where adv1 = ~S1.v | adv2.
- Grant is round-robin. last_grant resets to 1, so port 0 wins the first tie. If both ports are valid, the port != last_grant wins. A single valid port always wins. last_grant updates only on an accepted request.
- rsp_valid[i] = S2.v & (S2.owner==i) & ~flush[i].
- adv2 = ~S2.v | (S2 response handshake) | (S2 flushed this cycle).

Stall:
- If S2 is valid and its owner holds rsp_ready=0, then S2 holds, S1 holds if valid, and req_ready=0.
- Throughput is one op per cycle when there are no stalls.

Flush[i] (same cycle):
- S1 and S2 entries owned by i are invalidated at the next edge.
- rsp_valid[i] is masked immediately; a flush coinciding with rsp_ready loses the result.
- No request from i is granted that cycle. The other requester is unaffected and may be granted.
- Flushing S2 frees it, so S1 advances that cycle if it holds a surviving entry.

Reset (clrn=0 at an edge):
- S1.v=0, S2.v=0, last_grant=1.
- Outputs after reset: req_ready=2'b11 combinationally as soon as valid is seen; rsp_valid=0; rsp_prod=0; rsp_tag=0; idle=1.
- Reset mid-operation discards all in-flight ops with no response.

Datapath and outputs:
- Data registers load only on advance.
- rsp_prod and rsp_tag are zero whenever S2.v=0.
- Products are unsigned, full 52 bits, with no rounding (rounding is done by the requester).
- idle = ~S1.v & ~S2.v.

Decomposition:
- Shared constants header: MUL_W=26, MUL_PW=52, owner encodings OWN_FMUL=0 and OWN_FDIV=1, TW default.
- Sub-module: instantiate the existing wallace_26x26_product as the multiplier; arbitration and pipeline control stay in this module.
- Optional small sub-module rr_arb2 (2-way round-robin with last_grant register).

Test Plan:
- Single op: port 0 sends a=26'h3FFFFFF, b=26'h3FFFFFF, tag=5 → after 2 edges rsp_valid=2'b01, rsp_prod=52'hFFFFFF8000001, rsp_tag=5.
- Tie: both ports valid for 4 cycles (port 0 a=2,b=3; port 1 a=4,b=5) → grants alternate 0,1,0,1; responses 6,20,6,20 with matching owner bits.
- Backpressure: port 1 holds rsp_ready=0 for 3 cycles with S1 and S2 full → req_ready=0, S2 unchanged. rsp_ready rises → product 20 is delivered, then the S1 entry follows the next cycle.
- Flush: port 0 op in S2, port 1 op in S1, flush=2'b01 for 1 cycle → rsp_valid[0] never asserts; port 1 product appears the cycle after; port 0 request that cycle is not granted.
- Reset mid-operation: both stages full, clrn=0 for 1 edge → rsp_valid=0, idle=1 next cycle; first post-reset tie grants port 0.
- Random back-to-back: 1000 ops, random valid/ready/flush → every non-flushed op returns exactly once, in order per requester, with product a*b and the correct tag.
